risk_cache_arbiter: RTL and testbench

- Shares the single request port of the per-client risk cache between two requesters: CPU (new order / new max) and exchange (cancel/fill amount).
- Each requester has a valid/ready handshake into a one-deep holding register.
- A single-outstanding FSM issues one cache request at a time, waits for the cache done pulse, then returns the completion to the owning requester.
- Sits between the order-entry/exchange front ends and the upstream/downstream cache FSMs.

---
 rtl/risk_cache_arbiter_pkg.sv | 47 ++++
 rtl/risk_cache_arbiter_if.sv | 60 ++++++
 rtl/risk_cache_arbiter_hold_reg.sv | 60 ++++++
 rtl/risk_cache_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_risk_cache_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risk_cache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_def : shared definitions for the risk cache arbiter slice.
//
// Holds the width/limit constants used by the arbiter, its interface and the
// holding registers, the request-source and FSM-state enums, the packed request
// record that the arbiter presents to the cache, and a helper that widens an
// exchange amount onto the cache data bus.
//
// Constants:
//   CID_W       client id width (cache address width)
//   AMT_W       cache data / CPU amount width
//   EXCH_AMT_W  exchange amount width (zero-extended to AMT_W)
//   MAX_STARVE  consecutive exchange grants tolerated while a CPU request
//               waits (only used when STARVE_GUARD_EN is defined)
// -----------------------------------------------------------------------------
package cache_def;

    localparam int CID_W      = 5;
    localparam int AMT_W      = 32;
    localparam int EXCH_AMT_W = 16;
    localparam int MAX_STARVE = 4;

    typedef enum logic {
        SRC_CPU,
        SRC_EXCH
    } arb_src_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef struct packed {
        logic [CID_W-1:0] addr;
        logic [AMT_W-1:0] data;
        logic             rw;
        logic             max;
        arb_src_t         src;
    } arb_req_t;

    // Cancel/fill amounts are unsigned, so they are zero-extended.
    function automatic logic [AMT_W-1:0] exch_to_amt(input logic [EXCH_AMT_W-1:0] amt);
        return {{(AMT_W - EXCH_AMT_W){1'b0}}, amt};
    endfunction

endpackage

// File: rtl/risk_cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// risk_cache_arbiter_if : bundle of every handshake/bus signal around the
// risk cache arbiter.
//
// Signal groups:
//   cpu_*    CPU requester: valid/ready, client id, amount, new-max flag
//   exch_*   exchange requester: valid/ready, client id, 16-bit amount
//   cache_*  single request port to the cache plus its done pulse
//   cpu_done / exch_done  one-cycle completion pulses back to the requesters
//   busy     arbiter FSM not idle
//
// Modports:
//   slave   the arbiter itself (it serves both requesters and drives the cache)
//   master  the surroundings: requesters and the cache
// -----------------------------------------------------------------------------
interface risk_cache_arbiter_if;
    import cache_def::*;

    logic                  cpu_valid;
    logic                  cpu_ready;
    logic [CID_W-1:0]      cpu_client_id;
    logic [AMT_W-1:0]      cpu_amount;
    logic                  cpu_new_max;

    logic                  exch_valid;
    logic                  exch_ready;
    logic [CID_W-1:0]      exch_client_id;
    logic [EXCH_AMT_W-1:0] exch_amount;

    logic                  cache_req_valid;
    logic [CID_W-1:0]      cache_req_addr;
    logic [AMT_W-1:0]      cache_req_data;
    logic                  cache_req_rw;
    logic                  cache_req_max;
    logic                  cache_req_ready;
    logic                  cache_done;

    logic                  cpu_done;
    logic                  exch_done;
    logic                  busy;

    modport slave (
        input  cpu_valid, cpu_client_id, cpu_amount, cpu_new_max,
        input  exch_valid, exch_client_id, exch_amount,
        input  cache_req_ready, cache_done,
        output cpu_ready, exch_ready,
        output cache_req_valid, cache_req_addr, cache_req_data, cache_req_rw, cache_req_max,
        output cpu_done, exch_done, busy
    );

    modport master (
        output cpu_valid, cpu_client_id, cpu_amount, cpu_new_max,
        output exch_valid, exch_client_id, exch_amount,
        output cache_req_ready, cache_done,
        input  cpu_ready, exch_ready,
        input  cache_req_valid, cache_req_addr, cache_req_data, cache_req_rw, cache_req_max,
        input  cpu_done, exch_done, busy
    );

endinterface

// File: rtl/risk_cache_arbiter_hold_reg.sv
// -----------------------------------------------------------------------------
// arb_hold_reg : one-deep valid/ready holding register.
//
// Ports:
//   clk, HRESETn  clock and asynchronous active-low reset
//   valid_i       upstream has a request this cycle
//   ready_o       register is empty and will capture valid_i
//   data_i        request payload
//   clear_i       owner has finished with the held request
//   full_o        a request is being held
//   data_o        held payload
//
// The arbiter only clears a register that is full, and a full register never
// reports ready, so capture and clear never coincide.
// -----------------------------------------------------------------------------
module arb_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         HRESETn,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Next state: a clear empties the register, otherwise an empty register
    // takes whatever is offered and keeps it until cleared.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    // State register; reset leaves the register empty.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/risk_cache_arbiter.sv
// -----------------------------------------------------------------------------
// risk_cache_arbiter : shares the single request port of the per-client risk
// cache between the CPU (orders / new max) and the exchange (cancels / fills).
//
// Ports:
//   clk, HRESETn  clock and asynchronous active-low reset
//   bus           risk_cache_arbiter_if.slave: both requester handshakes, the
//                 cache request port, cache_done, cpu_done/exch_done, busy
//
// Each requester lands in its own one-deep holding register. A single-
// outstanding FSM (IDLE -> ISSUE -> WAIT) picks one held request, presents it
// until the cache accepts it, waits for cache_done, then pulses the owner's
// done and frees its register one cycle later.
//
// Arbitration: exchange wins by default because cancels reduce exposure
// before the risk check. When both target the same client the exchange always
// goes first.
//
// Build option STARVE_GUARD_EN: when defined, a counter tracks exchange grants
// made while a CPU request waits; once it reaches MAX_STARVE the CPU wins the
// next arbitration (unless the same-client rule applies). When undefined the
// exchange has strict priority and no counter exists.
// -----------------------------------------------------------------------------
module risk_cache_arbiter
    import cache_def::*;
(
    input logic                  clk,
    input logic                  HRESETn,
    risk_cache_arbiter_if.slave  bus
);

    localparam int CPU_W  = CID_W + AMT_W + 1;
    localparam int EXCH_W = CID_W + EXCH_AMT_W;

    logic                  cpu_full, exch_full;
    logic [CPU_W-1:0]      cpu_hold;
    logic [EXCH_W-1:0]     exch_hold;
    logic [CID_W-1:0]      cpu_cid, exch_cid;
    logic [AMT_W-1:0]      cpu_amt;
    logic [EXCH_AMT_W-1:0] exch_amt;
    logic                  cpu_nm;

    arb_state_t state_q, state_d;
    arb_req_t   req_q, req_d;
    arb_req_t   cpu_req, exch_req;
    logic       cpu_done_q, cpu_done_d;
    logic       exch_done_q, exch_done_d;
    logic       turn_q;
    logic       hold_off, grant, cpu_wins, same_client;

    arb_hold_reg #(.W(CPU_W)) u_cpu_hold (
        .clk     (clk),
        .HRESETn (HRESETn),
        .valid_i (bus.cpu_valid),
        .ready_o (bus.cpu_ready),
        .data_i  ({bus.cpu_client_id, bus.cpu_amount, bus.cpu_new_max}),
        .clear_i (cpu_done_q),
        .full_o  (cpu_full),
        .data_o  (cpu_hold)
    );

    arb_hold_reg #(.W(EXCH_W)) u_exch_hold (
        .clk     (clk),
        .HRESETn (HRESETn),
        .valid_i (bus.exch_valid),
        .ready_o (bus.exch_ready),
        .data_i  ({bus.exch_client_id, bus.exch_amount}),
        .clear_i (exch_done_q),
        .full_o  (exch_full),
        .data_o  (exch_hold)
    );

    assign {cpu_cid, cpu_amt, cpu_nm} = cpu_hold;
    assign {exch_cid, exch_amt}       = exch_hold;
    assign same_client                = (cpu_cid == exch_cid);

    // Arbitration pauses for two cycles after a done pulse: one while the
    // finished register is being freed and one while its ready is high, so a
    // requester that re-asserts valid straight away is captured in time to
    // compete in the next arbitration instead of silently forfeiting it.
    assign hold_off = cpu_done_q || exch_done_q || turn_q;
    assign grant    = (state_q == IDLE) && !hold_off && (cpu_full || exch_full);

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_STARVE + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          starve_hit;

    assign starve_hit = (starve_q == SW'(MAX_STARVE));

    // Starvation counter: counts exchange grants made while the CPU waits,
    // saturates at the limit (the same-client rule can keep granting the
    // exchange past it) and restarts on every CPU grant.
    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (cpu_wins) begin
                starve_d = '0;
            end else if (cpu_full && !starve_hit) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic starve_hit;

    assign starve_hit = 1'b0;
`endif

    assign cpu_wins = cpu_full && (!exch_full || (starve_hit && !same_client));

    // Candidate cache requests built from the two holding registers.
    always_comb begin
        cpu_req       = '0;
        cpu_req.addr  = cpu_cid;
        cpu_req.data  = cpu_amt;
        cpu_req.rw    = 1'b1;
        cpu_req.max   = cpu_nm;
        cpu_req.src   = SRC_CPU;

        exch_req      = '0;
        exch_req.addr = exch_cid;
        exch_req.data = exch_to_amt(exch_amt);
        exch_req.rw   = 1'b1;
        exch_req.max  = 1'b0;
        exch_req.src  = SRC_EXCH;
    end

    // FSM next state. The chosen request is latched on the IDLE->ISSUE
    // transition so the cache sees stable fields for as long as it stalls;
    // cache_done is only honoured in WAIT.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cpu_done_d  = 1'b0;
        exch_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    req_d   = cpu_wins ? cpu_req : exch_req;
                end
            end
            ISSUE: begin
                if (bus.cache_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.cache_done) begin
                    state_d = IDLE;
                    if (req_q.src == SRC_CPU) begin
                        cpu_done_d = 1'b1;
                    end else begin
                        exch_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, request and done-pulse registers. Reset aborts any transaction
    // without producing a done pulse.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cpu_done_q  <= 1'b0;
            exch_done_q <= 1'b0;
            turn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cpu_done_q  <= cpu_done_d;
            exch_done_q <= exch_done_d;
            turn_q      <= cpu_done_q || exch_done_q;
        end
    end

    assign bus.cache_req_valid = (state_q == ISSUE);
    assign bus.cache_req_addr  = req_q.addr;
    assign bus.cache_req_data  = req_q.data;
    assign bus.cache_req_rw    = req_q.rw;
    assign bus.cache_req_max   = req_q.max;
    assign bus.cpu_done        = cpu_done_q;
    assign bus.exch_done       = exch_done_q;
    assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_risk_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_risk_cache_arbiter : self-checking bench for risk_cache_arbiter.
//
// A small cache model lives inside tick(): it drives cache_req_ready, answers
// every accepted request with a cache_done pulse one cycle later (when
// enabled), logs accepted requests and counts done pulses. Single-request
// cases come from a vector table; contention, hazard, backpressure and reset
// cases are hand-written sequences. Expected starvation counts follow the
// STARVE_GUARD_EN build option.
// -----------------------------------------------------------------------------
module tb_risk_cache_arbiter;
    import cache_def::*;

    logic clk = 1'b0;
    logic HRESETn;

    always #5 clk = ~clk;

    risk_cache_arbiter_if bus ();

    risk_cache_arbiter dut (
        .clk     (clk),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

`ifdef STARVE_GUARD_EN
    localparam int STARVE_EXP = 4;
    localparam int HAZARD_EXP = 5;
`else
    localparam int STARVE_EXP = 6;
    localparam int HAZARD_EXP = 6;
`endif

    typedef struct {
        logic [CID_W-1:0] addr;
        logic [AMT_W-1:0] data;
        logic             rw;
        logic             mx;
    } seen_t;

    typedef struct {
        logic             isExch;
        logic [CID_W-1:0] cid;
        logic [AMT_W-1:0] amt;
        logic             newMax;
        logic [CID_W-1:0] expAddr;
        logic [AMT_W-1:0] expData;
        logic             expMax;
    } vec_t;

    int    testsRun    = 0;
    int    testsFailed = 0;
    int    cycleCnt    = 0;
    int    cpuDoneCnt;
    int    exchDoneCnt;
    int    exchBeforeCpu;
    logic  acceptEn;
    logic  autoDone;
    logic  injectDone;
    logic  acceptFlag;
    seen_t reqLog[$];
    vec_t  vecs[5];
    logic [CID_W-1:0] exchIds[8];

    // Free-running edge counter used to measure latencies.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and run the cache model there.
    task automatic tick();
        @(negedge clk);
        bus.cache_done      = acceptFlag | injectDone;
        injectDone          = 1'b0;
        bus.cache_req_ready = acceptEn;
        acceptFlag          = autoDone && bus.cache_req_valid && bus.cache_req_ready;
        if (bus.cache_req_valid && bus.cache_req_ready) begin
            reqLog.push_back('{bus.cache_req_addr, bus.cache_req_data, bus.cache_req_rw, bus.cache_req_max});
        end
        if (bus.cpu_done) begin
            cpuDoneCnt++;
            exchBeforeCpu = exchDoneCnt;
        end
        if (bus.exch_done) begin
            exchDoneCnt++;
        end
    endtask

    task automatic clearScoreboard();
        reqLog.delete();
        cpuDoneCnt    = 0;
        exchDoneCnt   = 0;
        exchBeforeCpu = -1;
    endtask

    // Offer one request for a single cycle; returns the capture edge number.
    task automatic applyStimulus(input vec_t v, output int capCycle);
        tick();
        if (v.isExch) begin
            bus.exch_client_id = v.cid;
            bus.exch_amount    = v.amt[EXCH_AMT_W-1:0];
            bus.exch_valid     = 1'b1;
        end else begin
            bus.cpu_client_id  = v.cid;
            bus.cpu_amount     = v.amt;
            bus.cpu_new_max    = v.newMax;
            bus.cpu_valid      = 1'b1;
        end
        tick();
        bus.cpu_valid  = 1'b0;
        bus.exch_valid = 1'b0;
        capCycle       = cycleCnt;
    endtask

    // CPU request held against a stream of nExch exchange requests whose
    // client ids come from exchIds and whose amounts are 1, 2, 3, ...
    task automatic runContention(input int nExch, input logic [CID_W-1:0] cpuCid);
        int   caps;
        logic cpuCaptured;
        caps        = 0;
        cpuCaptured = 1'b0;
        clearScoreboard();
        bus.cpu_client_id = cpuCid;
        bus.cpu_amount    = 32'd1000;
        bus.cpu_new_max   = 1'b0;
        for (int k = 0; k < 600 && !(cpuDoneCnt == 1 && exchDoneCnt == nExch); k++) begin
            tick();
            bus.cpu_valid = !cpuCaptured;
            if (bus.cpu_valid && bus.cpu_ready) begin
                cpuCaptured = 1'b1;
            end
            if (caps < nExch) begin
                bus.exch_valid     = 1'b1;
                bus.exch_client_id = exchIds[caps];
                bus.exch_amount    = 16'(caps + 1);
                if (bus.exch_ready) begin
                    caps++;
                end
            end else begin
                bus.exch_valid = 1'b0;
            end
        end
        bus.cpu_valid  = 1'b0;
        bus.exch_valid = 1'b0;
    endtask

    initial begin
        int   capCycle;
        int   latency;
        logic doneSeen;
        logic readyAtDone;

        HRESETn             = 1'b0;
        bus.cpu_valid       = 1'b0;
        bus.cpu_client_id   = '0;
        bus.cpu_amount      = '0;
        bus.cpu_new_max     = 1'b0;
        bus.exch_valid      = 1'b0;
        bus.exch_client_id  = '0;
        bus.exch_amount     = '0;
        bus.cache_req_ready = 1'b0;
        bus.cache_done      = 1'b0;
        acceptEn            = 1'b1;
        autoDone            = 1'b1;
        injectDone          = 1'b0;
        acceptFlag          = 1'b0;
        clearScoreboard();

        vecs[0] = '{1'b0, 5'd3,  32'd100,       1'b0, 5'd3,  32'd100,       1'b0};
        vecs[1] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 5'd0,  32'h0000_FFFF, 1'b0};
        vecs[3] = '{1'b1, 5'd17, 32'h0000_8001, 1'b0, 5'd17, 32'h0000_8001, 1'b0};
        vecs[4] = '{1'b0, 5'd10, 32'h1234_5678, 1'b1, 5'd10, 32'h1234_5678, 1'b1};

        // Reset state
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        checkOutput("reset cpu_ready", bus.cpu_ready, 1);
        checkOutput("reset exch_ready", bus.exch_ready, 1);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset cache_req_valid", bus.cache_req_valid, 0);
        checkOutput("reset dones", {bus.cpu_done, bus.exch_done}, 0);
        checkOutput("reset req fields", {bus.cache_req_addr, bus.cache_req_data, bus.cache_req_rw, bus.cache_req_max}, 0);

        // Single-request vectors with immediate cache ready and done
        for (int i = 0; i < 5; i++) begin
            clearScoreboard();
            applyStimulus(vecs[i], capCycle);
            checkOutput($sformatf("vec%0d ready low after capture", i),
                        vecs[i].isExch ? bus.exch_ready : bus.cpu_ready, 0);
            doneSeen    = 1'b0;
            latency     = -1;
            readyAtDone = 1'b1;
            for (int k = 0; k < 20 && !doneSeen; k++) begin
                tick();
                if (vecs[i].isExch ? bus.exch_done : bus.cpu_done) begin
                    doneSeen    = 1'b1;
                    latency     = cycleCnt - capCycle;
                    readyAtDone = vecs[i].isExch ? bus.exch_ready : bus.cpu_ready;
                end
            end
            checkOutput($sformatf("vec%0d done seen", i), doneSeen, 1);
            checkOutput($sformatf("vec%0d done latency", i), latency, 3);
            checkOutput($sformatf("vec%0d ready low during done", i), readyAtDone, 0);
            tick();
            checkOutput($sformatf("vec%0d ready after done", i),
                        vecs[i].isExch ? bus.exch_ready : bus.cpu_ready, 1);
            checkOutput($sformatf("vec%0d wrong-owner done", i),
                        vecs[i].isExch ? cpuDoneCnt : exchDoneCnt, 0);
            checkOutput($sformatf("vec%0d request count", i), reqLog.size(), 1);
            if (reqLog.size() > 0) begin
                checkOutput($sformatf("vec%0d addr", i), reqLog[0].addr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d data", i), reqLog[0].data, vecs[i].expData);
                checkOutput($sformatf("vec%0d rw", i), reqLog[0].rw, 1);
                checkOutput($sformatf("vec%0d max", i), reqLog[0].mx, vecs[i].expMax);
            end
            repeat (3) tick();
        end

        // Simultaneous requests: exchange first
        clearScoreboard();
        tick();
        bus.cpu_client_id  = 5'd2;
        bus.cpu_amount     = 32'd55;
        bus.cpu_new_max    = 1'b0;
        bus.cpu_valid      = 1'b1;
        bus.exch_client_id = 5'd5;
        bus.exch_amount    = 16'd7;
        bus.exch_valid     = 1'b1;
        tick();
        bus.cpu_valid  = 1'b0;
        bus.exch_valid = 1'b0;
        for (int k = 0; k < 40 && !(cpuDoneCnt == 1 && exchDoneCnt == 1); k++) begin
            tick();
        end
        checkOutput("simul request count", reqLog.size(), 2);
        if (reqLog.size() == 2) begin
            checkOutput("simul first addr", reqLog[0].addr, 5);
            checkOutput("simul first data", reqLog[0].data, 7);
            checkOutput("simul second addr", reqLog[1].addr, 2);
            checkOutput("simul second data", reqLog[1].data, 55);
        end
        checkOutput("simul exch done before cpu", exchBeforeCpu, 1);
        repeat (3) tick();

        // Starvation: exchange re-requests continuously while the CPU waits
        for (int i = 0; i < 8; i++) begin
            exchIds[i] = 5'd6;
        end
        runContention(6, 5'd1);
        checkOutput("starve cpu done", cpuDoneCnt, 1);
        checkOutput("starve exch dones", exchDoneCnt, 6);
        checkOutput("starve exch grants before cpu", exchBeforeCpu, STARVE_EXP);
        checkOutput("starve request count", reqLog.size(), 7);
        if (reqLog.size() == 7) begin
            checkOutput("starve cpu slot data", reqLog[STARVE_EXP].data, 1000);
        end
        repeat (3) tick();

        // Same-client hazard with the counter at its limit
        exchIds[0] = 5'd8;
        exchIds[1] = 5'd8;
        exchIds[2] = 5'd8;
        exchIds[3] = 5'd8;
        exchIds[4] = 5'd9;
        exchIds[5] = 5'd8;
        runContention(6, 5'd9);
        checkOutput("hazard cpu done", cpuDoneCnt, 1);
        checkOutput("hazard exch dones", exchDoneCnt, 6);
        checkOutput("hazard exch grants before cpu", exchBeforeCpu, HAZARD_EXP);
        checkOutput("hazard request count", reqLog.size(), 7);
        if (reqLog.size() == 7) begin
            checkOutput("hazard fifth grant", {reqLog[4].addr, reqLog[4].data}, {5'd9, 32'd5});
            checkOutput("hazard cpu slot data", reqLog[HAZARD_EXP].data, 1000);
        end
        repeat (3) tick();

        // Backpressure: cache_req_ready low for 5 cycles, stray done in ISSUE
        clearScoreboard();
        acceptEn = 1'b0;
        tick();
        bus.cpu_client_id = 5'd12;
        bus.cpu_amount    = 32'hDEAD_BEEF;
        bus.cpu_new_max   = 1'b1;
        bus.cpu_valid     = 1'b1;
        tick();
        bus.cpu_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.cache_req_valid; k++) begin
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("backpressure fields c%0d", k),
                        {bus.cache_req_valid, bus.cache_req_addr, bus.cache_req_data, bus.cache_req_rw, bus.cache_req_max},
                        {1'b1, 5'd12, 32'hDEAD_BEEF, 1'b1, 1'b1});
            if (k == 1) begin
                injectDone = 1'b1;
            end
            tick();
        end
        checkOutput("backpressure no early done", cpuDoneCnt, 0);
        acceptEn = 1'b1;
        for (int k = 0; k < 20 && cpuDoneCnt == 0; k++) begin
            tick();
        end
        checkOutput("backpressure done after accept", cpuDoneCnt, 1);
        checkOutput("backpressure accepted once", reqLog.size(), 1);
        repeat (3) tick();

        // Reset while waiting for cache_done
        clearScoreboard();
        autoDone = 1'b0;
        applyStimulus('{1'b1, 5'd4, 32'd3, 1'b0, 5'd4, 32'd3, 1'b0}, capCycle);
        for (int k = 0; k < 10 && reqLog.size() == 0; k++) begin
            tick();
        end
        tick();
        checkOutput("reset-wait busy before reset", bus.busy, 1);
        #2 HRESETn = 1'b0;
        #1;
        checkOutput("reset-wait busy", bus.busy, 0);
        checkOutput("reset-wait readies", {bus.cpu_ready, bus.exch_ready}, 2'b11);
        checkOutput("reset-wait cache_req_valid", bus.cache_req_valid, 0);
        tick();
        HRESETn    = 1'b1;
        injectDone = 1'b1;
        repeat (4) tick();
        checkOutput("reset-wait no done pulse", {cpuDoneCnt[7:0], exchDoneCnt[7:0]}, 0);
        checkOutput("reset-wait idle after late done", bus.busy, 0);
        checkOutput("reset-wait exch_ready", bus.exch_ready, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
